perf_sample_drain_ctrl: RTL
===========================

Name: perf_sample_drain_ctrl

Overview:
Write-back sequencer for the perf-counter event-based-sampling FIFO.
- Pops {event, pc} samples from the sampling FIFO one at a time.
- Formats each sample as a 64-bit record and writes it through a single-outstanding req/gnt/rsp memory port into a software ring buffer at the memory-mapped base address.
- Tracks the fill index, raises a watermark interrupt, and flags overflow and write errors.

Parameters:
- VLEN, 39, PC width of each sample.
- EVENT_W, 5, event-selector width (matches mhpmevent encoding).
- NUM_SLOTS, 256, ring-buffer capacity in records; power of two, at least 2.
- WATERMARK, 192, fill level that asserts irq_o; 1..NUM_SLOTS.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- enable_i  in  1  drain enable
- base_addr_i  in  64  buffer base; bits [2:0] ignored (treated as 0)
- clear_i  in  1  software acknowledge: reset index and flags
- sample_valid_i  in  1  FIFO not empty
- sample_event_i  in  EVENT_W  head sample event
- sample_pc_i  in  VLEN  head sample PC
- sample_ready_o  out  1  pop strobe
- mem_req_o  out  1  write request
- mem_gnt_i  in  1  request accepted
- mem_addr_o  out  64  write address
- mem_wdata_o  out  64  write data
- mem_rsp_valid_i  in  1  write completion
- mem_rsp_err_i  in  1  completion carries an error
- wr_idx_o  out  $clog2(NUM_SLOTS)+1  records committed since the last clear
- irq_o  out  1  watermark interrupt, level
- overflow_o  out  1  sticky: a sample was dropped because the buffer was full
- err_o  out  1  sticky: a write returned an error
- drop_cnt_o  out  16  dropped samples, saturating at 16'hFFFF

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): FSM=IDLE; every output is 0 (mem_addr_o and mem_wdata_o = 0); clear_pending=0.
- Record format: [63:64-EVENT_W]=event; [VLEN-1:0]=pc; all other bits 0. Records are captured into registers when popped.
- Slot address = base_addr_i[63:3]<<3 + (wr_idx mod NUM_SLOTS)*8.
- FSM IDLE:
  - Apply clear_pending if set, and stay in IDLE that cycle.
  - Otherwise, if enable_i && sample_valid_i:
    - wr_idx == NUM_SLOTS: pulse sample_ready_o for 1 cycle (drop), set overflow_o, drop_cnt++, stay in IDLE.
    - else: pulse sample_ready_o, latch the record and address, go to REQ.
- FSM REQ: mem_req_o=1 with stable addr/wdata until mem_gnt_i; on gnt go to WAIT. Request-to-grant latency is unbounded.
- FSM WAIT: mem_req_o=0. On mem_rsp_valid_i:
  - err=0: wr_idx++.
  - err=1: set err_o, drop_cnt++, wr_idx unchanged.
  - Both cases return to IDLE.
- Throughput: at most 1 record per 3 cycles (IDLE, REQ with same-cycle gnt, WAIT with next-cycle rsp).
- Exactly one write is outstanding at any time. A mem_rsp_valid_i outside WAIT is ignored.
- enable_i deassertion takes effect only in IDLE; an in-flight write always completes.
- irq_o = (wr_idx_o >= WATERMARK) registered, i.e. it follows wr_idx_o by 0 cycles; it drops only through clear.
- clear_i:
  - Sets clear_pending.
  - Applying it (IDLE only) sets wr_idx, irq_o, overflow_o, err_o and drop_cnt_o to 0, then clears clear_pending.
  - clear_i in IDLE is applied on the next cycle, and no pop happens in that cycle.
  - clear_i during REQ/WAIT waits for that write to complete; the completion's increment is then overwritten by the clear.
- drop_cnt saturates; it does not wrap.
- The buffer does not wrap: wr_idx stops at NUM_SLOTS until cleared.

Optional Feature:
PERF_SAMPLE_TIMESTAMP_EN
- Defined:
  - Adds input cycle_count_i[63:0], sampled at pop.
  - Each record is 2 words (16-byte stride): word 0 is the format above at slot*16, word 1 is the timestamp at slot*16+8.
  - FSM adds states REQ2 and WAIT2 after WAIT.
  - wr_idx increments only when both words complete without error. An error on either word sets err_o and drops the sample; a word-0 error skips word 1.
- Undefined: port absent, 1 word per record as above.

Test Plan:
- Reset, then enable=1, base=0x8000_0000, 3 samples (ev=5, pc=0x1000/0x1004/0x1008), gnt and rsp each 1 cycle -> writes at 0x8000_0000/08/10 with wdata 0x2800_0000_0000_1000..., wr_idx_o=3, irq_o=0.
- WATERMARK=4, NUM_SLOTS=4, 6 samples -> irq_o rises with wr_idx_o=4; remaining 2 popped without mem_req_o; overflow_o=1; drop_cnt_o=2.
- Second write returns rsp_err=1 -> err_o=1, drop_cnt_o=1, wr_idx_o=1 after 2 samples, next sample writes at slot 1 again.
- clear_i pulsed while in WAIT with wr_idx=5 -> completion occurs, then wr_idx_o=0 and all flags 0 one cycle after IDLE; next record goes to base+0.
- mem_gnt_i held low 10 cycles -> mem_req_o/addr/wdata stable for all 10; sample_ready_o=0 throughout; rst_ni=0 mid-REQ -> next cycle all outputs 0, FSM=IDLE.
- With PERF_SAMPLE_TIMESTAMP_EN, cycle_count_i=0x1234 at pop -> words at base+0 and base+8 = 0x1234, wr_idx_o=1.

Source files
------------

// File: rtl/perf_sample_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : perf_sample_drain_ctrl
// Purpose  : Write-back sequencer for the perf-counter event-based-sampling
//            FIFO. Pops one {event, pc} sample at a time, formats it as a
//            64-bit record and writes it through a single-outstanding
//            req/gnt/rsp port into a software ring buffer. Tracks the fill
//            index, raises a level watermark interrupt, and keeps sticky
//            overflow / write-error flags plus a saturating drop counter.
// Ports    : clk_i, rst_ni (sync, active-low)
//            enable_i, base_addr_i[63:0] (bits [2:0] ignored), clear_i
//            sample_valid_i, sample_event_i, sample_pc_i -> sample_ready_o
//            mem_req_o, mem_gnt_i, mem_addr_o, mem_wdata_o,
//            mem_rsp_valid_i, mem_rsp_err_i
//            wr_idx_o, irq_o, overflow_o, err_o, drop_cnt_o
// Option   : PERF_SAMPLE_TIMESTAMP_EN adds cycle_count_i[63:0]; each record
//            becomes two words (format word, then timestamp), 16-byte stride.
// Revision : 1.0 - initial release
// ============================================================================
module perf_sample_drain_ctrl #(
  parameter int VLEN      = 39,
  parameter int EVENT_W   = 5,
  parameter int NUM_SLOTS = 256,
  parameter int WATERMARK = 192
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enable_i,
  input  logic [63:0]                base_addr_i,
  input  logic                       clear_i,
  input  logic                       sample_valid_i,
  input  logic [EVENT_W-1:0]         sample_event_i,
  input  logic [VLEN-1:0]            sample_pc_i,
  output logic                       sample_ready_o,
  output logic                       mem_req_o,
  input  logic                       mem_gnt_i,
  output logic [63:0]                mem_addr_o,
  output logic [63:0]                mem_wdata_o,
  input  logic                       mem_rsp_valid_i,
  input  logic                       mem_rsp_err_i,
  output logic [$clog2(NUM_SLOTS):0] wr_idx_o,
  output logic                       irq_o,
  output logic                       overflow_o,
  output logic                       err_o,
  output logic [15:0]                drop_cnt_o
`ifdef PERF_SAMPLE_TIMESTAMP_EN
  ,
  input  logic [63:0]                cycle_count_i
`endif
);

  localparam int c_IDX_W = $clog2(NUM_SLOTS) + 1;
  localparam logic [c_IDX_W-1:0] c_FULL = c_IDX_W'(NUM_SLOTS);
  localparam logic [c_IDX_W-1:0] c_WM   = c_IDX_W'(WATERMARK);
`ifdef PERF_SAMPLE_TIMESTAMP_EN
  localparam int c_STRIDE_SH = 4;
`else
  localparam int c_STRIDE_SH = 3;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_REQ2  = 3'd3,
    S_WAIT2 = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_IDX_W-1:0]  r_idx;
  logic                r_irq;
  logic                r_ovf;
  logic                r_err;
  logic [15:0]         r_drop;
  logic                r_clr_pend;
  logic [63:0]         r_addr;
  logic [63:0]         r_wdata;
`ifdef PERF_SAMPLE_TIMESTAMP_EN
  logic [63:0]         r_ts;
  logic                w_load_w1;
`endif

  logic                w_pop;
  logic                w_apply;
  logic                w_full;
  logic                w_ovf_evt;
  logic                w_err_evt;
  logic                w_idx_inc;
  logic [c_IDX_W-1:0]  w_idx_nxt;
  logic [63:0]         w_slot_addr;
  logic [63:0]         w_rec;
  logic                w_base_unused;

  assign w_base_unused = ^base_addr_i[2:0];

  // The buffer never wraps, so the index only ever reaches NUM_SLOTS as the
  // "full" marker; the slot number is the index without its top bit.
  assign w_full      = (r_idx == c_FULL);
  assign w_idx_nxt   = r_idx + c_IDX_W'(1);
  assign w_slot_addr = {base_addr_i[63:3], 3'b000}
                     + (64'(r_idx[c_IDX_W-2:0]) << c_STRIDE_SH);

  always_comb begin
    w_rec                    = '0;
    w_rec[63 -: EVENT_W]     = sample_event_i;
    w_rec[VLEN-1:0]          = sample_pc_i;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_apply     = 1'b0;
    w_ovf_evt   = 1'b0;
    w_err_evt   = 1'b0;
    w_idx_inc   = 1'b0;
`ifdef PERF_SAMPLE_TIMESTAMP_EN
    w_load_w1   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        // A pending clear owns the cycle: no pop while it is applied.
        if (r_clr_pend) begin
          w_apply = 1'b1;
        end else if (enable_i && sample_valid_i) begin
          w_pop = 1'b1;
          if (w_full) begin
            w_ovf_evt = 1'b1;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt_i) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid_i) begin
          if (mem_rsp_err_i) begin
            w_err_evt   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
`ifdef PERF_SAMPLE_TIMESTAMP_EN
            w_load_w1   = 1'b1;
            w_state_nxt = S_REQ2;
`else
            w_idx_inc   = 1'b1;
            w_state_nxt = S_IDLE;
`endif
          end
        end
      end
`ifdef PERF_SAMPLE_TIMESTAMP_EN
      S_REQ2: begin
        if (mem_gnt_i) w_state_nxt = S_WAIT2;
      end
      S_WAIT2: begin
        if (mem_rsp_valid_i) begin
          w_err_evt   = mem_rsp_err_i;
          w_idx_inc   = ~mem_rsp_err_i;
          w_state_nxt = S_IDLE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_irq      <= 1'b0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
      r_drop     <= '0;
      r_clr_pend <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
`ifdef PERF_SAMPLE_TIMESTAMP_EN
      r_ts       <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      // A new clear request wins over retiring the one being applied.
      r_clr_pend <= clear_i | (r_clr_pend & ~w_apply);
      if (w_apply) begin
        r_idx  <= '0;
        r_irq  <= 1'b0;
        r_ovf  <= 1'b0;
        r_err  <= 1'b0;
        r_drop <= '0;
      end else begin
        if (w_idx_inc) begin
          r_idx <= w_idx_nxt;
          // Registered alongside the index so irq_o tracks wr_idx_o exactly.
          if (w_idx_nxt >= c_WM) r_irq <= 1'b1;
        end
        if (w_ovf_evt) r_ovf <= 1'b1;
        if (w_err_evt) r_err <= 1'b1;
        if ((w_ovf_evt || w_err_evt) && (r_drop != 16'hFFFF)) begin
          r_drop <= r_drop + 16'd1;
        end
      end
      if (w_pop && !w_full) begin
        r_addr  <= w_slot_addr;
        r_wdata <= w_rec;
`ifdef PERF_SAMPLE_TIMESTAMP_EN
        r_ts    <= cycle_count_i;
`endif
      end
`ifdef PERF_SAMPLE_TIMESTAMP_EN
      if (w_load_w1) begin
        r_addr  <= r_addr + 64'd8;
        r_wdata <= r_ts;
      end
`endif
    end
  end

  // Pop strobe is combinational; hold it off while reset is asserted.
  assign sample_ready_o = w_pop & rst_ni;
  assign mem_req_o      = (r_state == S_REQ) || (r_state == S_REQ2);
  assign mem_addr_o     = r_addr;
  assign mem_wdata_o    = r_wdata;
  assign wr_idx_o       = r_idx;
  assign irq_o          = r_irq;
  assign overflow_o     = r_ovf;
  assign err_o          = r_err;
  assign drop_cnt_o     = r_drop;

endmodule
`default_nettype wire
